// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch
// Purpose  : Single-outstanding instruction fetch unit with redirect support.
// Revision : 1.0 - initial release
// ============================================================================
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_raw,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] w_redirect_target;

    // Every value loaded into r_pc is word-aligned, so the address needs no masking.
    assign w_redirect_target = redirect_pc & c_align_mask;
    assign imem_req          = (r_state == S_REQ);
    assign imem_addr         = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC & c_align_mask;
            r_state     <= S_REQ;
            instr_valid <= 1'b0;
            instr_raw   <= 32'h0;
            instr_pc    <= 32'h0;
        end else if (redirect_valid) begin
            // An in-flight request must be drained so its data never reaches decode.
            r_pc        <= w_redirect_target;
            instr_valid <= 1'b0;
            case (r_state)
                S_REQ:   r_state <= imem_ready  ? S_DRAIN : S_REQ;
                S_WAIT:  r_state <= imem_rvalid ? S_REQ   : S_DRAIN;
                S_HOLD:  r_state <= S_REQ;
                S_DRAIN: r_state <= imem_rvalid ? S_REQ   : S_DRAIN;
                default: r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr_raw   <= imem_rdata;
                        instr_pc    <= r_pc;
                        instr_valid <= 1'b1;
                        r_pc        <= r_pc + 32'd4;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        r_state     <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule
`default_nettype wire
